// File: rtl/dm_arbiter_pkg.sv
// Shared types for the data-memory arbiter.
// Read-owner enum and the default starvation limit.
package dm_arbiter_pkg;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_CPU  = 2'd1,
    RD_DBG  = 2'd2
  } rd_owner_e;

  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/dm_arb_starve.sv
// Saturating count of consecutive lost debug cycles.
// In: clk, rstn, dbg_req, dbg_gnt. Out: force_gnt (count hit limit).
module dm_arb_starve
  import dm_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic dbg_req,
  input  logic dbg_gnt,
  output logic force_gnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_MAX);

  logic [3:0] cnt;

  assign force_gnt = (cnt == LIMIT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= 4'd0;
    end else if (!dbg_req || dbg_gnt) begin
      cnt <= 4'd0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// CPU/debug arbiter in front of a 1-cycle synchronous data memory.
// Ports: cpu_* and dbg_* request groups, dm_* memory port;
// perf_cpu_stall/perf_dbg_gnt only with DM_ARB_PERF_EN defined.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [3:0]        cpu_be,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [3:0]        dbg_be,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              dm_en,
  output logic [3:0]        dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata
`ifdef DM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_cpu_stall,
  output logic [31:0]       perf_dbg_gnt
`endif
);

  logic      force_gnt;
  logic      cpu_gnt;
  rd_owner_e rd_owner;

  dm_arb_starve #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rstn     (rstn),
    .dbg_req  (dbg_req),
    .dbg_gnt  (dbg_gnt),
    .force_gnt(force_gnt)
  );

  // CPU has priority unless debug has starved long enough.
  assign dbg_gnt   = dbg_req & (~cpu_req | force_gnt);
  assign cpu_gnt   = cpu_req & ~dbg_gnt;
  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_comb begin
    dm_en    = 1'b0;
    dm_we    = 4'b0000;
    dm_addr  = '0;
    dm_wdata = '0;
    unique case (1'b1)
      dbg_gnt: begin
        dm_en    = 1'b1;
        dm_we    = dbg_we ? dbg_be : 4'b0000;
        dm_addr  = dbg_addr;
        dm_wdata = dbg_wdata;
      end
      cpu_gnt: begin
        dm_en    = 1'b1;
        dm_we    = cpu_we ? cpu_be : 4'b0000;
        dm_addr  = cpu_addr;
        dm_wdata = cpu_wdata;
      end
      default: ;
    endcase
  end

  // Tracks who the memory's next-cycle read data belongs to.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_owner <= RD_NONE;
    end else begin
      unique case (1'b1)
        cpu_gnt & ~cpu_we: rd_owner <= RD_CPU;
        dbg_gnt & ~dbg_we: rd_owner <= RD_DBG;
        default:           rd_owner <= RD_NONE;
      endcase
    end
  end

  assign cpu_rvalid = (rd_owner == RD_CPU);
  assign dbg_rvalid = (rd_owner == RD_DBG);
  assign cpu_rdata  = cpu_rvalid ? dm_rdata : 32'd0;
  assign dbg_rdata  = dbg_rvalid ? dm_rdata : 32'd0;

`ifdef DM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_cpu_stall <= 32'd0;
      perf_dbg_gnt   <= 32'd0;
    end else begin
      if (cpu_stall) perf_cpu_stall <= perf_cpu_stall + 32'd1;
      if (dbg_gnt)   perf_dbg_gnt   <= perf_dbg_gnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed cases plus random traffic
// compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_dm_arbiter;

  localparam int SMAX = 4;
  localparam int W_NONE = 0;
  localparam int W_CPU  = 1;
  localparam int W_DBG  = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cpu_req = 0, cpu_we = 0;
  logic [3:0]  cpu_be = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic        dbg_req = 0, dbg_we = 0;
  logic [3:0]  dbg_be = 0;
  logic [31:0] dbg_addr = 0, dbg_wdata = 0;
  logic [31:0] dm_rdata = 0;
  logic        cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, dm_en;
  logic [31:0] cpu_rdata, dbg_rdata, dm_addr, dm_wdata;
  logic [3:0]  dm_we;
`ifdef DM_ARB_PERF_EN
  logic [31:0] perf_cpu_stall, perf_dbg_gnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #25 clk = ~clk;

  dm_arbiter #(.ADDR_W(32), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_be(dbg_be),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata),
    .dm_en(dm_en), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
`ifdef DM_ARB_PERF_EN
    , .perf_cpu_stall(perf_cpu_stall),
    .perf_dbg_gnt(perf_dbg_gnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Model: lost-cycle count, who gets next-cycle read data,
  // and event counts.
  int          m_lost;
  int          m_rd_who;
  logic [31:0] m_nstall, m_ndgnt;

  function automatic bit e_dgnt();
    return dbg_req && (!cpu_req || m_lost == SMAX);
  endfunction

  function automatic bit e_cgnt();
    return cpu_req && !e_dgnt();
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_lost   <= 0;
      m_rd_who <= W_NONE;
      m_nstall <= 0;
      m_ndgnt  <= 0;
    end else begin
      if (!dbg_req || e_dgnt()) m_lost <= 0;
      else m_lost <= (m_lost + 1 > SMAX) ? SMAX : m_lost + 1;
      if (e_cgnt() && !cpu_we)      m_rd_who <= W_CPU;
      else if (e_dgnt() && !dbg_we) m_rd_who <= W_DBG;
      else                          m_rd_who <= W_NONE;
      if (cpu_req && !e_cgnt()) m_nstall <= m_nstall + 1;
      if (e_dgnt())             m_ndgnt  <= m_ndgnt + 1;
    end
  end

  always @(negedge clk) begin
    bit gd, gc;
    logic [3:0] wbe;
    gd = e_dgnt();
    gc = e_cgnt();
    wbe = gd ? (dbg_we ? dbg_be : 4'h0)
             : (gc ? (cpu_we ? cpu_be : 4'h0) : 4'h0);
    chk("dbg_gnt", 32'(dbg_gnt), 32'(gd));
    chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !gc));
    chk("dm_en", 32'(dm_en), 32'(gd || gc));
    chk("dm_we", 32'(dm_we), 32'(wbe));
    if (gd || gc) begin
      chk("dm_addr", dm_addr, gd ? dbg_addr : cpu_addr);
      chk("dm_wdata", dm_wdata, gd ? dbg_wdata : cpu_wdata);
    end
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_rd_who == W_CPU));
    chk("dbg_rvalid", 32'(dbg_rvalid), 32'(m_rd_who == W_DBG));
    chk("cpu_rdata", cpu_rdata, m_rd_who == W_CPU ? dm_rdata : 0);
    chk("dbg_rdata", dbg_rdata, m_rd_who == W_DBG ? dm_rdata : 0);
`ifdef DM_ARB_PERF_EN
    chk("perf_stall", perf_cpu_stall, m_nstall);
    chk("perf_dgnt", perf_dbg_gnt, m_ndgnt);
`endif
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; dbg_req = 0; dbg_we = 0;
  endtask

  initial begin
    // Reset state.
    @(negedge clk);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("rst_dbg_rvalid", 32'(dbg_rvalid), 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dm_en", 32'(dm_en), 0);
    go(); rstn = 1;

    // CPU-only read.
    go();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0C;
    @(negedge clk);
    chk("c32_dm_en", 32'(dm_en), 1);
    chk("c32_stall", 32'(cpu_stall), 0);
    go(); idle(); dm_rdata = 32'h12345678;
    @(negedge clk);
    chk("c32_rvalid", 32'(cpu_rvalid), 1);
    chk("c32_rdata", cpu_rdata, 32'h12345678);
    chk("c32_dbg_rvalid", 32'(dbg_rvalid), 0);

    // Debug write.
    go();
    dbg_req = 1; dbg_we = 1; dbg_be = 4'b0011;
    dbg_addr = 0; dbg_wdata = 32'hAABBCCDD;
    @(negedge clk);
    chk("c33_gnt", 32'(dbg_gnt), 1);
    chk("c33_we", 32'(dm_we), 32'h3);
    go(); idle();
    @(negedge clk);
    chk("c33_no_dbg_rvalid", 32'(dbg_rvalid), 0);
    chk("c33_no_cpu_rvalid", 32'(cpu_rvalid), 0);

    // Contention from a fresh reset: debug forced on 5th cycle.
    go(); rstn = 0;
    go(); rstn = 1;
    cpu_req = 1; cpu_we = 0; dbg_req = 1; dbg_we = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("c34_dgnt", 32'(dbg_gnt), 32'(i == 4 || i == 9));
      chk("c34_stall", 32'(cpu_stall), 32'(i == 4 || i == 9));
      go();
    end
    idle();
`ifdef DM_ARB_PERF_EN
    @(negedge clk);
    chk("c37_perf_dgnt", perf_dbg_gnt, 2);
    chk("c37_perf_stall", perf_cpu_stall, 2);
`endif

    // Alternating reads.
    go();
    cpu_req = 1; cpu_addr = 32'h40;
    go();
    cpu_req = 0; dbg_req = 1; dbg_addr = 32'h80;
    dm_rdata = 32'h11112222;
    @(negedge clk);
    chk("c35_cpu_rvalid", 32'(cpu_rvalid), 1);
    chk("c35_cpu_rdata", cpu_rdata, 32'h11112222);
    chk("c35_dbg_rvalid0", 32'(dbg_rvalid), 0);
    go(); idle(); dm_rdata = 32'h33334444;
    @(negedge clk);
    chk("c35_dbg_rvalid", 32'(dbg_rvalid), 1);
    chk("c35_dbg_rdata", dbg_rdata, 32'h33334444);
    chk("c35_cpu_rvalid0", 32'(cpu_rvalid), 0);
    chk("c35_cpu_rdata0", cpu_rdata, 0);

    // Reset mid-read.
    go(); cpu_req = 1;
    go(); idle(); dm_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("c36_rvalid_pre", 32'(cpu_rvalid), 1);
    #5 rstn = 0;
    #1;
    chk("c36_rvalid_rst", 32'(cpu_rvalid), 0);
    chk("c36_rdata_rst", cpu_rdata, 0);
    go(); go(); rstn = 1;
    @(negedge clk);
    chk("c36_rvalid_post", 32'(cpu_rvalid), 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      go();
      rstn      = ($urandom_range(199) != 0);
      cpu_req   = ($urandom_range(9) < 7);
      cpu_we    = $urandom_range(1);
      cpu_be    = 4'($urandom);
      cpu_addr  = $urandom;
      cpu_wdata = $urandom;
      dbg_req   = ($urandom_range(9) < 6);
      dbg_we    = ($urandom_range(3) == 0);
      dbg_be    = 4'($urandom);
      dbg_addr  = $urandom;
      dbg_wdata = $urandom;
      dm_rdata  = $urandom;
    end
    go(); rstn = 1; idle();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the byte-address width on every port.
REQ-002 The block SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive lost debug cycles before debug is forced a grant (legal range 1..15).
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rstn, input, 1: reset, asynchronous and active-low.
REQ-005 Port cpu_req, input, 1: the MEM stage requests a data-memory access this cycle.
REQ-006 Ports cpu_we (in, 1), cpu_be (in, 4), cpu_addr (in, ADDR_W), cpu_wdata (in, 32): write enable, byte enables, byte address and write data from the CPU.
REQ-007 Port cpu_stall, output, 1: the CPU request was not granted this cycle; the pipeline holds.
REQ-008 Ports cpu_rvalid (out, 1) and cpu_rdata (out, 32): CPU read data is valid.
REQ-009 Ports dbg_req, dbg_we, dbg_be, dbg_addr, dbg_wdata mirror the CPU request group for the debug/loader port.
REQ-010 Ports dbg_gnt (out, 1), dbg_rvalid (out, 1) and dbg_rdata (out, 32): debug grant, read-valid and read data.
REQ-011 Ports dm_en (out, 1), dm_we (out, 4), dm_addr (out, ADDR_W), dm_wdata (out, 32) and dm_rdata (in, 32): the data-memory port; the memory has a synchronous read with 1-cycle latency.

Function
REQ-012 At most one requester SHALL be granted per cycle; the grant is combinational from the current-cycle inputs.
REQ-013 The CPU SHALL win when both request, unless starve_cnt equals STARVE_MAX, in which case debug wins.
REQ-014 starve_cnt SHALL increment, saturating at STARVE_MAX, on each cycle where dbg_req=1 and debug is not granted; it SHALL clear on a debug grant or whenever dbg_req=0.
REQ-015 cpu_stall SHALL equal cpu_req AND NOT cpu_grant; it SHALL be 0 when cpu_req=0.
REQ-016 When a requester is granted, dm_en SHALL be 1, dm_addr and dm_wdata SHALL come from the winner, and dm_we SHALL be the winner's be when we=1, otherwise 4'b0000.
REQ-017 With no grant, dm_en SHALL be 0 and dm_we SHALL be 0; dm_addr and dm_wdata are don't-care.
REQ-018 A registered read-owner state SHALL take one of three values: RD_NONE, RD_CPU or RD_DBG. It is loaded each cycle from the current grant when we=0, and is otherwise RD_NONE.
REQ-019 The owner's rvalid SHALL be 1 in the cycle after a granted read. rdata SHALL equal dm_rdata for the owner and 0 for the non-owner.
REQ-020 Back-to-back reads by alternating owners SHALL each return in order with no bubble.
REQ-021 A write SHALL produce no rvalid.
REQ-022 Withdrawing a request without a grant SHALL be legal and SHALL leave no pending state beyond the starve_cnt clear.

Reset
REQ-023 Asserting rstn low SHALL asynchronously force the read owner to RD_NONE and starve_cnt to 0.
REQ-024 During reset, the outputs SHALL be: cpu_rvalid=0, dbg_rvalid=0, cpu_rdata=0, dbg_rdata=0. dm_en, dm_we, cpu_stall and dbg_gnt SHALL follow the combinational rules.
REQ-025 A read in flight when reset asserts SHALL be dropped, with no rvalid after release.

Configuration
REQ-026 With macro DM_ARB_PERF_EN defined, the block SHALL add two output counters, each 32 bits: perf_cpu_stall (cycles with cpu_stall=1) and perf_dbg_gnt (debug grants).
REQ-027 The performance counters SHALL wrap at 2^32 and reset to 0.
REQ-028 Without DM_ARB_PERF_EN, those ports and their registers SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 A shared package SHALL hold the read-owner enum (RD_NONE/RD_CPU/RD_DBG) and the STARVE_MAX default constant.
REQ-030 A single sub-module, dm_arb_starve, SHALL hold the saturating starve counter and its force-grant output.
REQ-031 The rest of the block, including grant, mux and return routing, SHALL stay in dm_arbiter.

Verification
REQ-032 CPU-only read: cpu_req=1, we=0, addr=0x0C, memory word 0x12345678.
  - Same cycle: dm_en=1, cpu_stall=0.
  - Next cycle: cpu_rvalid=1, cpu_rdata=0x12345678, dbg_rvalid=0.
REQ-033 Debug write: dbg_req=1, we=1, be=4'b0011, addr=0x00, wdata=0xAABBCCDD.
  - dbg_gnt=1, dm_we=4'b0011.
  - No rvalid the following cycle.
REQ-034 Contention, STARVE_MAX=4: cpu_req and dbg_req held high.
  - Cycles 0-3: CPU granted.
  - Cycle 4: dbg_gnt=1, cpu_stall=1.
  - Cycle 5: CPU granted again, starve_cnt=0.
REQ-035 Alternating reads: CPU read at cycle n, debug read at n+1.
  - cpu_rvalid at n+1, dbg_rvalid at n+2.
  - Each carries its own dm_rdata.
REQ-036 Reset mid-read: granted CPU read, then rstn low 20 ns before the next edge.
  - cpu_rvalid=0 immediately and stays 0 after release.
REQ-037 With DM_ARB_PERF_EN defined, run the REQ-034 pattern for 10 cycles.
  - Required: perf_dbg_gnt=2, perf_cpu_stall=2.
